// File: rtl/obi_timer.sv
// OBI-attached prescaled 32-bit timer with compare match and optional interrupt.
// Define OBI_TIMER_IRQ_EN to build the CTRL.IRQEN bit and the registered irq_o path.
module obi_timer #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        irq_o
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    logic                  ctrl_en;
    logic                  ctrl_ar;
    logic                  ctrl_irqen;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] psc_cnt;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  match;

    logic [2:0]            offset;
    logic                  access_ok;
    logic                  wr;
    logic                  wr_prescale;
    logic                  tick;
    logic                  match_hit;
    logic [31:0]           rd_val;
    logic [PRESCALE_W-1:0] prescale_wr;
    logic                  unused_addr;

    function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    assign gnt_o       = req_i;
    assign unused_addr = ^addr_i[31:5];
    assign offset      = addr_i[4:2];
    assign access_ok   = req_i && (addr_i[1:0] == 2'b00) && (offset <= OFF_STATUS);
    assign wr          = access_ok && we_i && (be_i != 4'b0000);
    assign wr_prescale = wr && (offset == OFF_PRESCALE);
    assign tick        = ctrl_en && (psc_cnt == prescale);
    assign match_hit   = tick && (count == compare);

    always_comb begin
        prescale_wr = prescale;
        for (int b = 0; b < int'(PRESCALE_W); b++) begin
            if (be_i[b/8]) prescale_wr[b] = wdata_i[b];
        end
    end

    always_comb begin
        rd_val = '0;
        case (offset)
            OFF_CTRL:     rd_val[2:0] = {ctrl_irqen, ctrl_ar, ctrl_en};
            OFF_PRESCALE: rd_val[PRESCALE_W-1:0] = prescale;
            OFF_COUNT:    rd_val = count;
            OFF_COMPARE:  rd_val = compare;
            OFF_STATUS:   rd_val[0] = match;
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
            ctrl_en  <= 1'b0;
            ctrl_ar  <= 1'b0;
            prescale <= '0;
            psc_cnt  <= '0;
            count    <= '0;
            compare  <= '0;
            match    <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            err_o    <= req_i && !access_ok;
            rdata_o  <= (access_ok && !we_i) ? rd_val : '0;

            if (wr && offset == OFF_CTRL && be_i[0]) begin
                ctrl_en <= wdata_i[0];
                ctrl_ar <= wdata_i[1];
            end
            if (wr_prescale) prescale <= prescale_wr;
            if (wr && offset == OFF_COMPARE) compare <= byte_merge(compare, wdata_i, be_i);

            if (!ctrl_en || wr_prescale || tick) psc_cnt <= '0;
            else                                 psc_cnt <= psc_cnt + 1'b1;

            // A bus write to COUNT overrides the tick update; match still uses the old COUNT.
            if (wr && offset == OFF_COUNT)       count <= byte_merge(count, wdata_i, be_i);
            else if (tick)                       count <= (match_hit && ctrl_ar) ? 32'd0 : count + 32'd1;

            if (match_hit)                       match <= 1'b1;
            else if (wr && offset == OFF_STATUS && be_i[0] && wdata_i[0]) match <= 1'b0;
        end
    end

`ifdef OBI_TIMER_IRQ_EN
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ctrl_irqen <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            if (wr && offset == OFF_CTRL && be_i[0]) ctrl_irqen <= wdata_i[2];
            irq_o <= match && ctrl_irqen;
        end
    end
`else
    assign ctrl_irqen = 1'b0;
    assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_obi_timer.sv
// Randomized scoreboard bench for obi_timer against a cycle-level behavioural model.
module tb_obi_timer;

    localparam int PW = 16;
`ifdef OBI_TIMER_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [31:0] addr_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        irq_o;

    obi_timer #(.PRESCALE_W(PW)) dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .irq_o(irq_o)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic        en, ar, ie;
        logic [31:0] presc, phase, count, compare;
        logic        match, irq;
    } st_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } resp_t;

    st_t   cur = '0;
    st_t   nxt = '0;
    resp_t exp_q[$];
    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input st_t s, input logic [2:0] off);
        case (off)
            3'd0: return {29'd0, s.ie, s.ar, s.en};
            3'd1: return s.presc;
            3'd2: return s.count;
            3'd3: return s.compare;
            3'd4: return {31'd0, s.match};
            default: return 32'd0;
        endcase
    endfunction

    // State in the next cycle, from the register/timer rules applied to this cycle's state and request.
    function automatic st_t model_next(input st_t s, input logic rq, input logic we,
                                       input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        st_t n = s;
        logic ok  = rq && a[1:0] == 2'b00 && a[4:2] < 3'd5;
        logic w   = ok && we && be != 4'd0;
        logic [2:0] off = a[4:2];
        logic tk  = s.en && s.phase == s.presc;
        logic hit = tk && s.count == s.compare;
        n.phase = (!s.en || (w && off == 3'd1) || tk) ? 32'd0 : s.phase + 32'd1;
        if (tk) n.count = (hit && s.ar) ? 32'd0 : s.count + 32'd1;
        if (hit) n.match = 1'b1;
        if (w) begin
            case (off)
                3'd0: if (be[0]) begin n.en = wd[0]; n.ar = wd[1]; n.ie = IRQ & wd[2]; end
                3'd1: n.presc = merge(s.presc, wd, be) & ((32'd1 << PW) - 32'd1);
                3'd2: n.count = merge(s.count, wd, be);
                3'd3: n.compare = merge(s.compare, wd, be);
                3'd4: if (be[0] && wd[0] && !hit) n.match = 1'b0;
                default: ;
            endcase
        end
        n.irq = IRQ & s.match & s.ie;
        return n;
    endfunction

    task automatic step(input logic rq, input logic we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
        resp_t r;
        @(posedge clk_sys); #1;
        cur = nxt;
        req_i = rq; we_i = we; addr_i = a; be_i = be; wdata_i = wd;
        if (rq) begin
            r.err   = !(a[1:0] == 2'b00 && a[4:2] < 3'd5);
            r.rdata = (!r.err && !we) ? model_read(cur, a[4:2]) : 32'd0;
            r.due   = cyc + 1;
            exp_q.push_back(r);
        end
        nxt = model_next(cur, rq, we, a, be, wd);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d); step(1, 1, {27'd0, a}, 4'hF, d); endtask
    task automatic rd(input logic [4:0] a); step(1, 0, {27'd0, a}, 4'hF, 32'd0); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) step(0, 0, 32'd0, 4'h0, 32'd0); endtask

    task automatic rand_step();
        logic [2:0]  off = 3'($urandom_range(0, 7));
        logic [1:0]  mis = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        logic [31:0] a = $urandom();
        logic [31:0] d = $urandom();
        logic [3:0]  be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        a[4:0] = {off, mis};
        case (off)
            3'd0: d[0] = ($urandom_range(0, 3) != 0);
            3'd1: d = $urandom_range(0, 3);
            3'd2, 3'd3: if ($urandom_range(0, 3) != 0) d = $urandom_range(0, 12);
            default: ;
        endcase
        step($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), a, be, d);
    endtask

    task automatic clear_timer();
        wr(5'h00, 32'h0); wr(5'h08, 32'h0); wr(5'h10, 32'h1); idle(2);
    endtask

    // Response monitor: pops one expectation per rvalid and flags missing or spurious responses.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk_sys);
            if (rvalid_o === 1'b1) begin
                if (exp_q.size() == 0) check("spurious_rvalid", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("rdata", rdata_o, e.rdata);
                    check("err", {31'd0, err_o}, {31'd0, e.err});
                    check("resp_cycle", cyc, e.due);
                end
            end else begin
                check("idle_outputs", {rdata_o[30:0], err_o}, 32'd0);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    check("missing_rvalid", 32'd0, 32'd1);
                    void'(exp_q.pop_front());
                end
            end
            check("irq", {31'd0, irq_o}, {31'd0, cur.irq});
        end
    end

    initial begin
        idle(3);
        rst_sys_n = 1'b1;
        idle(2);

        wr(5'h0C, 32'd5); wr(5'h04, 32'd0); wr(5'h00, 32'h1);
        idle(7); rd(5'h10); rd(5'h08); rd(5'h08);
        clear_timer();

        wr(5'h0C, 32'd3); wr(5'h04, 32'd2); wr(5'h00, 32'h3);
        for (int i = 0; i < 16; i++) rd(5'h08);
        rd(5'h10);
        clear_timer();

        rd(5'h08); wr(5'h0C, 32'h1234); rd(5'h18);
        rd(5'h01); wr(5'h02, 32'hFFFF_FFFF); rd(5'h0C); rd(5'h1C);

        step(1, 1, 32'h8, 4'b0001, 32'hFFFF_FFFF); rd(5'h08);
        step(1, 1, 32'h8, 4'b0000, 32'h0);         rd(5'h08);
        wr(5'h04, 32'd0); wr(5'h08, 32'hFFFF_FFFF); wr(5'h00, 32'h1); rd(5'h08); rd(5'h08);
        clear_timer();

        wr(5'h04, 32'd0); wr(5'h0C, 32'd2); wr(5'h00, 32'h7);
        idle(6);
        wr(5'h08, 32'd0); idle(2); wr(5'h10, 32'h1);
        rd(5'h10); idle(2); rd(5'h10); wr(5'h00, 32'h5); rd(5'h00);
        clear_timer();

        for (int i = 0; i < 3000; i++) rand_step();

        wr(5'h08, 32'h55); wr(5'h00, 32'h7); rd(5'h08);
        @(negedge clk_sys); #1;
        rst_sys_n = 1'b0; req_i = 1'b0;
        exp_q.delete(); cur = '0; nxt = '0;
        #1;
        check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_gnt", {31'd0, gnt_o}, 32'd0);
        idle(2);
        rst_sys_n = 1'b1;
        for (int i = 0; i < 5; i++) rd(5'(i * 4));

        for (int i = 0; i < 1500; i++) rand_step();
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
